// File: rtl/dpy_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dpy_pkg
// Brief   : Shared types, constants and the seven-segment font for the
//           multiplexed display scanner.
// Revision: 1.0 - initial release
// ============================================================================
package dpy_pkg;

  // Control FSM of the scanner: capture, optional BCD conversion, commit.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Double-dabble correction: digits at or above 5 get 3 added before the shift.
  localparam logic [3:0] BCD_ADJ_MIN = 4'd5;
  localparam logic [3:0] BCD_ADD3    = 4'd3;

  // Nibble to {g,f,e,d,c,b,a}, 1 = lit.
  function automatic logic [6:0] seg_font(input logic [3:0] nib);
    logic [6:0] f;
    case (nib)
      4'h0: f = 7'h3F;
      4'h1: f = 7'h06;
      4'h2: f = 7'h5B;
      4'h3: f = 7'h4F;
      4'h4: f = 7'h66;
      4'h5: f = 7'h6D;
      4'h6: f = 7'h7D;
      4'h7: f = 7'h07;
      4'h8: f = 7'h7F;
      4'h9: f = 7'h6F;
      4'hA: f = 7'h77;
      4'hB: f = 7'h7C;
      4'hC: f = 7'h39;
      4'hD: f = 7'h5E;
      4'hE: f = 7'h79;
      default: f = 7'h71;
    endcase
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module  : bin2bcd_seq
// Brief   : Sequential double-dabble converter, one input bit per cycle, MSB
//           first. Keeps the low N_DIGITS BCD digits and flags any carry out
//           of the top digit as a sticky overflow.
// Revision: 1.0 - initial release
// ============================================================================
module bin2bcd_seq
  import dpy_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int N_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin,
  output logic                    done,
  output logic [4*N_DIGITS-1:0]   bcd,
  output logic                    ovf
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int BCD_W = 4 * N_DIGITS;

  logic [DATA_W-1:0] sh;
  logic [CNT_W-1:0]  cnt;
  logic [BCD_W-1:0]  adj;

  // Add-3 correction on every digit that would overflow past 9 when doubled.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= BCD_ADJ_MIN) begin
        adj[4*i +: 4] = bcd[4*i +: 4] + BCD_ADD3;
      end
    end
  end

  // Load on start, then shift one bit per cycle; the bit leaving the top
  // digit is a carry worth 10^N_DIGITS and is only remembered as overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh  <= '0;
      cnt <= '0;
      bcd <= '0;
      ovf <= 1'b0;
    end else if (start) begin
      sh  <= bin;
      cnt <= CNT_W'(DATA_W);
      bcd <= '0;
      ovf <= 1'b0;
    end else if (cnt != '0) begin
      bcd <= {adj[BCD_W-2:0], sh[DATA_W-1]};
      ovf <= ovf | adj[BCD_W-1];
      sh  <= sh << 1;
      cnt <= cnt - 1'b1;
    end
  end

  // High during the cycle whose closing edge shifts in the last bit.
  assign done = (cnt == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/dpy_scan_multi.sv
`default_nettype none
// ============================================================================
// Module  : dpy_scan_multi
// Brief   : Multiplexed N-digit seven-segment driver with hex/decimal
//           rendering, leading-zero blanking, per-digit decimal points, PWM
//           brightness and a load/busy handshake with atomic commit.
// Revision: 1.0 - initial release
// ============================================================================
module dpy_scan_multi
  import dpy_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int DATA_W   = 32,
  parameter int SCAN_DIV = 16500,
  parameter int PWM_BITS = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DATA_W-1:0]   number_in,
  input  logic [N_DIGITS-1:0] dp_in,
  input  logic                mode_dec,
  input  logic                blank_lz,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                load,
  output logic                busy,
  output logic                ovf,
  output logic [7:0]          digit,
  output logic [N_DIGITS-1:0] segment
);

  localparam int NIB_W = 4 * N_DIGITS;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int SC_W  = $clog2(SCAN_DIV);

  state_e              state;
  logic                commit_pend;
  logic [NIB_W-1:0]    sh_hex;
  logic [N_DIGITS-1:0] sh_dp;
  logic                sh_blank;
  logic                sh_dec;

  logic [NIB_W-1:0]    disp_nib;
  logic [N_DIGITS-1:0] disp_dp;
  logic                disp_blank;

  logic [SC_W-1:0]     scan_cnt;
  logic [IDX_W-1:0]    idx;
  logic [PWM_BITS-1:0] pwm_cnt;

  logic [NIB_W-1:0]    hex_val;
  logic                accept;
  logic                bcd_start;
  logic                bcd_done;
  logic [NIB_W-1:0]    bcd_val;
  logic                bcd_ovf;

  logic [N_DIGITS-1:0] blank_mask;
  logic [N_DIGITS-1:0] sel;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic                pwm_en;

  // Fit the input to the hex digit field: drop nibbles beyond N_DIGITS or
  // zero-extend a narrow input.
  generate
    if (DATA_W >= NIB_W) begin : g_hex_trunc
      assign hex_val = number_in[NIB_W-1:0];
    end else begin : g_hex_ext
      assign hex_val = {{(NIB_W - DATA_W){1'b0}}, number_in};
    end
  endgenerate

  assign accept    = (state == ST_IDLE) && load && !busy;
  assign bcd_start = accept && mode_dec;

  bin2bcd_seq #(
    .DATA_W   (DATA_W),
    .N_DIGITS (N_DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (bcd_start),
    .bin     (number_in),
    .done    (bcd_done),
    .bcd     (bcd_val),
    .ovf     (bcd_ovf)
  );

  // Capture/convert/commit sequencing; busy drops one edge after the commit
  // so the new display is already on the pins when the host sees idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      commit_pend <= 1'b0;
      sh_hex      <= '0;
      sh_dp       <= '0;
      sh_blank    <= 1'b0;
      sh_dec      <= 1'b0;
      disp_nib    <= '0;
      disp_dp     <= '0;
      disp_blank  <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      commit_pend <= 1'b0;
      if (commit_pend) begin
        busy <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sh_hex   <= hex_val;
            sh_dp    <= dp_in;
            sh_blank <= blank_lz;
            sh_dec   <= mode_dec;
            busy     <= 1'b1;
            state    <= mode_dec ? ST_CONV : ST_COMMIT;
          end
        end
        ST_CONV: begin
          if (bcd_done) begin
            state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          disp_nib    <= sh_dec ? bcd_val : sh_hex;
          disp_dp     <= sh_dp;
          disp_blank  <= sh_blank;
          ovf         <= sh_dec & bcd_ovf;
          commit_pend <= 1'b1;
          state       <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Digit dwell counter, digit index and free-running PWM phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt <= '0;
      idx      <= '0;
      pwm_cnt  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (scan_cnt == SC_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

  // Leading-zero mask: everything above the highest non-zero digit; digit 0
  // is never above anything, so it always shows.
  always_comb begin
    int hi;
    hi = 0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (disp_nib[4*i +: 4] != 4'd0) begin
        hi = i;
      end
    end
    for (int i = 0; i < N_DIGITS; i++) begin
      blank_mask[i] = disp_blank && (i > hi);
    end
  end

  // Select the currently scanned digit's nibble, dp and blank state.
  always_comb begin
    cur_nib   = 4'd0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    sel       = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib   = disp_nib[4*i +: 4];
        cur_dp    = disp_dp[i];
        cur_blank = blank_mask[i];
        sel[i]    = 1'b1;
      end
    end
  end

  assign pwm_en = (pwm_cnt < brightness) || (&brightness);

  // Registered pin drivers; everything dark during the PWM off phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit   <= 8'd0;
      segment <= '0;
    end else if (pwm_en) begin
      digit   <= {cur_dp, cur_blank ? 7'd0 : seg_font(cur_nib)};
      segment <= sel;
    end else begin
      digit   <= 8'd0;
      segment <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dpy_scan_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_dpy_scan_multi
// Brief   : Scoreboard bench for dpy_scan_multi. Stimulus pushes the expected
//           display for each accepted load; a negedge monitor pops on the
//           busy falling edge and checks the scanned pins every cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dpy_scan_multi;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int SD = 4;
  localparam int PB = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] number_in = '0;
  logic [N-1:0]  dp_in = '0;
  logic          mode_dec = 1'b0;
  logic          blank_lz = 1'b0;
  logic [PB-1:0] brightness = 2'd3;
  logic          load = 1'b0;
  logic          busy;
  logic          ovf;
  logic [7:0]    digit;
  logic [N-1:0]  segment;

  dpy_scan_multi #(
    .N_DIGITS (N),
    .DATA_W   (DW),
    .SCAN_DIV (SD),
    .PWM_BITS (PB)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .number_in  (number_in),
    .dp_in      (dp_in),
    .mode_dec   (mode_dec),
    .blank_lz   (blank_lz),
    .brightness (brightness),
    .load       (load),
    .busy       (busy),
    .ovf        (ovf),
    .digit      (digit),
    .segment    (segment)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pat [N];
    bit         ovf;
    int         blen;
  } txn_t;

  txn_t sb_q [$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [7:0]    exp_pat [N];
  bit            exp_ovf;
  int            edge_cnt = 0;
  logic [PB-1:0] br_at_edge = '0;
  bit            prev_busy = 0;
  int            busy_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: render the value as digits arithmetically, then apply blanking and dp.
  function automatic txn_t model(input int unsigned v, input logic [N-1:0] dp,
                                 input bit dec, input bit bl);
    txn_t t;
    int d [N];
    int r;
    int hi;
    r = int'(v % 10000);
    for (int i = 0; i < N; i++) begin
      if (dec) begin
        d[i] = r % 10;
        r = r / 10;
      end else begin
        d[i] = int'((v >> (4 * i)) & 32'hF);
      end
    end
    hi = 0;
    for (int i = 0; i < N; i++) if (d[i] != 0) hi = i;
    for (int i = 0; i < N; i++)
      t.pat[i] = {dp[i], (bl && i > hi) ? 7'h00 : font[d[i]]};
    t.ovf  = dec && (v >= 10000);
    t.blen = dec ? DW + 2 : 2;
    return t;
  endfunction

  task automatic reset_display_model();
    for (int i = 0; i < N; i++) exp_pat[i] = {1'b0, font[0]};
    exp_ovf = 0;
  endtask

  initial reset_display_model();

  // Track edges since reset release and the brightness each edge saw.
  always @(posedge clk) begin
    if (!reset_n) edge_cnt = 0;
    else edge_cnt = edge_cnt + 1;
    br_at_edge = brightness;
  end

  // Monitor: commit check on busy fall, then per-cycle scan/PWM check.
  always @(negedge clk) begin
    txn_t t;
    int   p;
    int   ix;
    bit   en;
    if (!reset_n) begin
      prev_busy = 0;
      busy_len  = 0;
      reset_display_model();
      check("rst_segment", 32'(segment), 0);
      check("rst_digit", 32'(digit), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_ovf", 32'(ovf), 0);
    end else begin
      if (busy) begin
        busy_len++;
      end else if (prev_busy) begin
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_underflow: commit seen with no expected load, busy_len=%0d", busy_len);
        end else begin
          t = sb_q.pop_front();
          check("busy_len", 32'(busy_len), 32'(t.blen));
          check("commit_ovf", 32'(ovf), 32'(t.ovf));
          exp_pat = t.pat;
          exp_ovf = t.ovf;
        end
        busy_len = 0;
      end
      prev_busy = busy;
      if (edge_cnt == 0) begin
        check("post_rst_segment", 32'(segment), 0);
        check("post_rst_digit", 32'(digit), 0);
      end else begin
        p  = (edge_cnt - 1) % (1 << PB);
        ix = ((edge_cnt - 1) / SD) % N;
        en = (p < int'(br_at_edge)) || (br_at_edge == 2'd3);
        check("segment", 32'(segment), en ? (32'd1 << ix) : 32'd0);
        check("digit", 32'(digit), en ? 32'(exp_pat[ix]) : 32'd0);
      end
      if (!busy) check("ovf_hold", 32'(ovf), 32'(exp_ovf));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idle: busy=1 after %0d cycles, want 0", k);
    end
  endtask

  // Called at a negedge; drives one load pulse, pushing an expectation if it must be accepted.
  task automatic issue(input logic [DW-1:0] v, input logic [N-1:0] dp,
                       input bit dec, input bit bl, input bit accepted);
    number_in = v;
    dp_in     = dp;
    mode_dec  = dec;
    blank_lz  = bl;
    load      = 1'b1;
    if (accepted) sb_q.push_back(model(int'(v), dp, dec, bl));
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] rv;
    reset_n = 1'b0;
    tick(3);
    #1 reset_n = 1'b1;
    tick(6);

    // Hex commit
    brightness = 2'd3;
    issue(16'h1A2F, 4'b0000, 0, 0, 1);
    wait_idle();
    tick(20);

    // Decimal, with a load pulsed mid-conversion that must be ignored
    issue(16'd1234, 4'b0000, 1, 0, 1);
    tick(5);
    issue(16'd9999, 4'b1111, 0, 1, 0);
    wait_idle();
    tick(20);

    // Overflow, then blanking with a decimal point on a blank digit
    issue(16'd12345, 4'b0000, 1, 0, 1);
    wait_idle();
    tick(20);
    issue(16'd7, 4'b0100, 1, 1, 1);
    wait_idle();
    tick(20);

    // Brightness sweep
    brightness = 2'd0;
    tick(16);
    brightness = 2'd1;
    tick(16);
    brightness = 2'd2;
    tick(16);
    brightness = 2'd3;
    tick(8);

    // Reset in the middle of a decimal conversion
    issue(16'd4321, 4'b0011, 1, 0, 0);
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_busy", 32'(busy), 0);
    check("async_ovf", 32'(ovf), 0);
    check("async_digit", 32'(digit), 0);
    check("async_segment", 32'(segment), 0);
    tick(3);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("no_commit_busy", 32'(busy), 0);
    end

    // Randomized transactions
    for (int n = 0; n < 24; n++) begin
      wait_idle();
      rv = ($urandom_range(0, 1) == 1) ? DW'($urandom_range(0, 65535)) : DW'($urandom_range(0, 300));
      brightness = PB'($urandom_range(0, 3));
      issue(rv, N'($urandom_range(0, 15)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1);
      if ($urandom_range(0, 2) == 0) begin
        tick(1);
        issue(DW'($urandom), N'($urandom_range(0, 15)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0);
      end
      wait_idle();
      tick($urandom_range(2, 14));
    end
    brightness = 2'd3;
    tick(20);

    check("sb_drained", 32'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
